// File: rtl/uart_tx.sv
// 8-bit UART transmitter: a small byte FIFO feeding an LSB-first 8N1/8N2 serialiser.
// TX is registered and idles high; state_dbg exposes the FSM state.
module uart_tx #(
    parameter int TICKS_PER_BIT = 16,
    parameter int FIFO_DEPTH    = 4,
    parameter int STOP_BITS     = 1
) (
    input  logic                        sys_clk,
    input  logic                        reset,
    input  logic [7:0]                  data_in,
    input  logic                        data_valid,
    output logic                        data_accept,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        tx_busy,
    output logic                        TX,
    output logic [1:0]                  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int TICK_W = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic              STOP_LAST = (STOP_BITS == 2);

    // Handshake: a byte transfers on every rising edge where data_valid && data_accept.
    // data_accept depends only on the registered count, so a full FIFO refuses a
    // write even when the serialiser pops in the same cycle.

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;
    logic             fifo_empty;

    assign data_accept = (count < DEPTH_C);
    assign push        = data_valid & data_accept;
    assign fifo_empty  = (count == '0);
    assign fifo_count  = count;

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= data_valid & ~data_accept;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    state_t            state;
    state_t            state_d;
    logic [TICK_W-1:0] tick;
    logic [TICK_W-1:0] tick_d;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_d;
    logic              stop_idx;
    logic              stop_idx_d;
    logic [7:0]        shift;
    logic [7:0]        shift_d;
    logic              tx_d;
    logic              tick_done;

    assign tick_done = (tick == TICK_LAST);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state    <= IDLE;
            tick     <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shift    <= '0;
            TX       <= 1'b1;
        end else begin
            state    <= state_d;
            tick     <= tick_d;
            bit_idx  <= bit_idx_d;
            stop_idx <= stop_idx_d;
            shift    <= shift_d;
            TX       <= tx_d;
        end
    end

    always_comb begin
        state_d    = state;
        tick_d     = tick;
        bit_idx_d  = bit_idx;
        stop_idx_d = stop_idx;
        shift_d    = shift;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = mem[rd_ptr];
                    tick_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (tick_done) begin
                    tick_d    = '0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end else begin
                    tick_d = tick + TICK_W'(1);
                end
            end
            DATA: begin
                if (tick_done) begin
                    tick_d  = '0;
                    shift_d = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        stop_idx_d = 1'b0;
                        state_d    = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 3'd1;
                    end
                end else begin
                    tick_d = tick + TICK_W'(1);
                end
            end
            STOP: begin
                if (tick_done) begin
                    tick_d = '0;
                    if (stop_idx == STOP_LAST) begin
                        // Back-to-back frames: the next start bit follows the last stop tick.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            shift_d = mem[rd_ptr];
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end else begin
                    tick_d = tick + TICK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // TX is registered from next-state values so the line changes on the same edge as the state.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign tx_busy   = (state != IDLE);
    assign state_dbg = state;

endmodule
